// File: rtl/alu_nibble_serial_adder.sv
// alu_nibble_serial_adder: WIDTH-bit add/sub on one reused 4-bit carry-lookahead slice, one nibble per cycle
module alu_nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW = $clog2(NSLICE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       p, g, c, s;
    logic             pg, gg, co, last, accept;

    // Carry-lookahead slice on the nibble selected by the counter; c[0] is the chained carry
    always_comb begin
        p    = opa[{cnt, 2'b00} +: 4] ^ opb[{cnt, 2'b00} +: 4];
        g    = opa[{cnt, 2'b00} +: 4] & opb[{cnt, 2'b00} +: 4];
        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g[1] | (g[0] & p[1]) | (carry & p[0] & p[1]);
        c[3] = g[2] | (g[1] & p[2]) | (g[0] & p[1] & p[2]) | (carry & p[0] & p[1] & p[2]);
        pg   = &p;
        gg   = g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3]);
        co   = gg | (pg & carry);
        s    = p ^ c;
        last = cnt == CW'(NSLICE - 1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = state == IDLE;
        out_valid  = state == DONE;
        busy       = state != IDLE;
        accept     = in_valid && state == IDLE;
        case (state)
            IDLE:    state_next = accept ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at accept, one nibble of result per RUN cycle, flags on the last nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum[{cnt, 2'b00} +: 4] <= s;
            carry <= co;
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
                cout <= co;
                ovf  <= c[3] ^ co;
            end
        end
    end
endmodule

// File: tb/tb_alu_nibble_serial_adder.sv
// tb_alu_nibble_serial_adder: directed checks of the nibble-serial adder at WIDTH=8 and WIDTH=32
module tb_alu_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors = 0;

    logic       iv8 = 1'b0, or8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, co8, of8, bz8;
    logic [7:0] s8;

    logic        iv32 = 1'b0, or32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ir32, ov32, co32, of32, bz32;
    logic [31:0] s32;

    always #5 clk = ~clk;

    alu_nibble_serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
    );

    alu_nibble_serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(sub32),
        .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32), .busy(bz32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a8 = x; b8 = y; sub8 = s; iv8 = 1'b1; or8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b0; a8 = ~x; b8 = 8'h5A; sub8 = ~s;
        chk({tag, " run0 out_valid"}, 32'(ov8), 32'd0);
        chk({tag, " run0 in_ready"}, 32'(ir8), 32'd0);
        @(negedge clk);
        chk({tag, " run1 out_valid"}, 32'(ov8), 32'd0);
        @(negedge clk);
        chk({tag, " done out_valid"}, 32'(ov8), 32'd1);
        chk({tag, " sum"}, 32'(s8), 32'(es));
        chk({tag, " cout"}, 32'(co8), 32'(ec));
        chk({tag, " ovf"}, 32'(of8), 32'(eo));
        or8 = 1'b1;
        @(negedge clk);
        chk({tag, " idle in_ready"}, 32'(ir8), 32'd1);
        or8 = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst8 in_ready", 32'(ir8), 32'd1);
        chk("rst8 out_valid", 32'(ov8), 32'd0);
        chk("rst8 busy", 32'(bz8), 32'd0);
        chk("rst32 sum", s32, 32'd0);
        chk("rst32 cout/ovf", 32'({co32, of32}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op8("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub 05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("add a5+3c", 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0);

        // 32-bit: in_valid held three cycles, exactly one accept, eight RUN cycles
        @(negedge clk);
        a32 = 32'h0FFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; iv32 = 1'b1; or32 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) iv32 = 1'b0;
            chk($sformatf("w32 run%0d in_ready", i), 32'(ir32), 32'd0);
            chk($sformatf("w32 run%0d out_valid", i), 32'(ov32), 32'd0);
        end
        @(negedge clk);
        chk("w32 out_valid", 32'(ov32), 32'd1);
        chk("w32 sum", s32, 32'h1000_0000);
        chk("w32 cout/ovf", 32'({co32, of32}), 32'd0);

        // Backpressure with a pending request
        a32 = 32'h1111_1111; b32 = 32'h2222_2222; iv32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d out_valid", i), 32'(ov32), 32'd1);
            chk($sformatf("bp%0d in_ready", i), 32'(ir32), 32'd0);
            chk($sformatf("bp%0d sum", i), s32, 32'h1000_0000);
            chk($sformatf("bp%0d cout/ovf", i), 32'({co32, of32}), 32'd0);
        end
        or32 = 1'b1;
        @(negedge clk);
        chk("handoff in_ready", 32'(ir32), 32'd1);
        chk("handoff out_valid", 32'(ov32), 32'd0);
        chk("handoff sum held", s32, 32'h1000_0000);
        @(negedge clk);
        chk("pending accepted busy", 32'(bz32), 32'd1);
        chk("pending accepted in_ready", 32'(ir32), 32'd0);
        iv32 = 1'b0; or32 = 1'b0;

        // Asynchronous reset during slice 1
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst out_valid", 32'(ov32), 32'd0);
        chk("arst sum", s32, 32'd0);
        chk("arst in_ready", 32'(ir32), 32'd1);
        chk("arst busy", 32'(bz32), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        a32 = 32'h12; b32 = 32'h34; sub32 = 1'b0; iv32 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            iv32 = 1'b0;
            chk($sformatf("post-rst run%0d out_valid", i), 32'(ov32), 32'd0);
        end
        @(negedge clk);
        chk("post-rst out_valid", 32'(ov32), 32'd1);
        chk("post-rst sum", s32, 32'h46);
        chk("post-rst cout/ovf", 32'({co32, of32}), 32'd0);

        // 32-bit subtract with borrow: 0 - 1
        or32 = 1'b1;
        @(negedge clk);
        a32 = 32'h0; b32 = 32'h1; sub32 = 1'b1; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0; or32 = 1'b0;
        repeat (8) @(negedge clk);
        chk("sub32 out_valid", 32'(ov32), 32'd1);
        chk("sub32 sum", s32, 32'hFFFF_FFFF);
        chk("sub32 cout/ovf", 32'({co32, of32}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
